// File: rtl/instr_byte_queue.sv
// Byte-granular instruction queue: 16-byte fetch lines in, head-aligned
// 16-byte decode window out, variable-length retire per cycle.
module instr_byte_queue #(
  parameter int LINE_BYTES  = 16,
  parameter int DEPTH_BYTES = 32,
  parameter int WIN_BYTES   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    fetch_valid,
  input  logic [8*LINE_BYTES-1:0] fetch_line,
  output logic                    fetch_ready,
  output logic [8*WIN_BYTES-1:0]  dec_window,
  output logic [4:0]              dec_count,
  input  logic                    dec_consume,
  input  logic [3:0]              dec_len,
  output logic                    dec_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          legal;
  logic          wr;
  logic          rd;

  assign fetch_ready = count <= CW'(LINE_BYTES);
  assign legal = (dec_len != 4'd0) && (CW'(dec_len) <= count);
  assign wr = fetch_valid & fetch_ready & ~flush;
  assign rd = dec_consume & ~flush & legal;

  always_comb begin
    count_next = count;
    if (wr) count_next = count_next + CW'(LINE_BYTES);
    if (rd) count_next = count_next - CW'(dec_len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dec_err <= 1'b0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dec_err <= 1'b0;
    end else begin
      if (wr) tail <= tail + AW'(LINE_BYTES);
      if (rd) head <= head + AW'(dec_len);
      count   <= count_next;
      dec_err <= dec_consume & ~legal;
    end
  end

  // Storage needs no reset; the window masks bytes beyond count.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        mem[tail + AW'(i)] <= fetch_line[8*(LINE_BYTES-1-i) +: 8];
      end
    end
  end

  always_comb begin
    dec_window = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      if (CW'(i) < count) begin
        dec_window[8*(WIN_BYTES-1-i) +: 8] = mem[head + AW'(i)];
      end
    end
  end

  assign dec_count = (count > CW'(WIN_BYTES)) ? 5'(WIN_BYTES)
                                              : 5'(count);

endmodule

// File: tb/tb_instr_byte_queue.sv
// Scoreboard bench for instr_byte_queue: stimulus pushes expected
// post-edge snapshots; a negedge monitor pops and compares them.
module tb_instr_byte_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         fetch_valid;
  logic [127:0] fetch_line;
  logic         fetch_ready;
  logic [127:0] dec_window;
  logic [4:0]   dec_count;
  logic         dec_consume;
  logic [3:0]   dec_len;
  logic         dec_err;

  typedef struct {
    string        name;
    logic [127:0] win;
    logic [4:0]   cnt;
    logic         rdy;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  instr_byte_queue dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .fetch_valid(fetch_valid),
    .fetch_line(fetch_line),
    .fetch_ready(fetch_ready),
    .dec_window(dec_window),
    .dec_count(dec_count),
    .dec_consume(dec_consume),
    .dec_len(dec_len),
    .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] seq(input logic [7:0] s,
                                       input int n);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[127-8*i -: 8] = s + 8'(i);
    return w;
  endfunction

  function automatic exp_t mk(input string nm, input logic [7:0] s,
                              input int n, input logic rdy,
                              input logic err);
    exp_t x;
    x.name = nm;
    x.win  = seq(s, n);
    x.cnt  = 5'(n);
    x.rdy  = rdy;
    x.err  = err;
    return x;
  endfunction

  // Drive one cycle of inputs; expectation is for the cycle after the edge.
  task automatic apply(input logic fv, input logic [7:0] lb,
                       input logic dc, input logic [3:0] len,
                       input logic fl, input string nm,
                       input logic [7:0] s, input int n,
                       input logic rdy, input logic err);
    fetch_valid = fv;
    fetch_line  = seq(lb, 16);
    dec_consume = dc;
    dec_len     = len;
    flush       = fl;
    @(posedge clk);
    #1;
    sb.push_back(mk(nm, s, n, rdy, err));
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0;
    fetch_line  = '0;
    dec_consume = 1'b0;
    dec_len     = 4'd0;
    flush       = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (dec_window !== e.win || dec_count !== e.cnt ||
          fetch_ready !== e.rdy || dec_err !== e.err) begin
        fails++;
        $display("FAIL %s: got win=%h cnt=%0d rdy=%b err=%b, want win=%h cnt=%0d rdy=%b err=%b",
                 e.name, dec_window, dec_count, fetch_ready, dec_err,
                 e.win, e.cnt, e.rdy, e.err);
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    sb.push_back(mk("reset", 8'h00, 0, 1'b1, 1'b0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    apply(1, 8'h00, 0, 4'd0,  0, "wr_line0",   8'h00, 16, 1, 0);
    apply(0, 8'h00, 1, 4'd3,  0, "consume3",   8'h03, 13, 1, 0);
    apply(1, 8'h10, 0, 4'd0,  0, "wr_line1",   8'h03, 16, 0, 0);
    apply(1, 8'h20, 0, 4'd0,  0, "drop_full",  8'h03, 16, 0, 0);
    apply(0, 8'h00, 1, 4'd15, 0, "consume15a", 8'h12, 14, 1, 0);
    apply(1, 8'h20, 0, 4'd0,  0, "wrap_read",  8'h12, 16, 0, 0);
    apply(0, 8'h00, 1, 4'd15, 0, "consume15b", 8'h21, 15, 1, 0);
    apply(1, 8'h30, 1, 4'd3,  1, "flush_a",    8'h00, 0,  1, 0);

    apply(1, 8'h00, 0, 4'd0,  0, "b_wr0",      8'h00, 16, 1, 0);
    apply(1, 8'h10, 0, 4'd0,  0, "b_full",     8'h00, 16, 0, 0);
    apply(0, 8'h00, 1, 4'd15, 0, "b_cons15a",  8'h0F, 16, 0, 0);
    apply(0, 8'h00, 1, 4'd15, 0, "b_cons15b",  8'h1E, 2,  1, 0);
    apply(1, 8'h20, 0, 4'd0,  0, "b_wrap_win", 8'h1E, 16, 0, 0);
    apply(0, 8'h00, 1, 4'd2,  0, "b_cons2",    8'h20, 16, 1, 0);
    apply(1, 8'h30, 1, 4'd4,  0, "wr_and_rd",  8'h24, 16, 0, 0);
    apply(0, 8'h00, 1, 4'd15, 0, "c_cons15",   8'h33, 13, 1, 0);
    apply(0, 8'h00, 1, 4'd11, 0, "c_cons11",   8'h3E, 2,  1, 0);
    apply(0, 8'h00, 1, 4'd5,  0, "illegal5",   8'h3E, 2,  1, 1);
    apply(0, 8'h00, 0, 4'd0,  0, "err_clear1", 8'h3E, 2,  1, 0);
    apply(0, 8'h00, 1, 4'd0,  0, "illegal0",   8'h3E, 2,  1, 1);
    apply(0, 8'h00, 0, 4'd0,  0, "err_clear2", 8'h3E, 2,  1, 0);
    apply(0, 8'h00, 1, 4'd2,  0, "drain",      8'h00, 0,  1, 0);
    apply(0, 8'h00, 1, 4'd1,  0, "empty_cons", 8'h00, 0,  1, 1);
    apply(0, 8'h00, 0, 4'd0,  0, "err_clear3", 8'h00, 0,  1, 0);

    apply(1, 8'h40, 0, 4'd0,  0, "d_wr4",      8'h40, 16, 1, 0);
    apply(0, 8'h00, 1, 4'd12, 0, "d_cons12",   8'h4C, 4,  1, 0);
    apply(1, 8'h50, 0, 4'd0,  0, "d_wr5",      8'h4C, 16, 0, 0);
    apply(1, 8'h60, 1, 4'd3,  1, "flush_20",   8'h00, 0,  1, 0);
    apply(0, 8'h00, 1, 4'd5,  1, "flush_ill",  8'h00, 0,  1, 0);
    apply(1, 8'h60, 0, 4'd0,  0, "e_wr6",      8'h60, 16, 1, 0);
    apply(0, 8'h00, 1, 4'd2,  0, "e_cons2",    8'h62, 14, 1, 0);

    // Reset between edges; the monitor samples before the next edge.
    idle_inputs();
    @(posedge clk);
    #2 reset = 1'b1;
    sb.push_back(mk("async_reset", 8'h00, 0, 1'b1, 1'b0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    apply(1, 8'h70, 0, 4'd0,  0, "post_reset", 8'h70, 16, 1, 0);
    idle_inputs();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
